// File: rtl/tx_frame_pkg.sv
// Shared types and helpers for the solution transmit framer.
// The row extractor works on a fixed 256-bit view so any board up to 16x16 fits.
package tx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        FINISH
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam logic [7:0] DIM_ERR_BYTE   = 8'hFF;
    localparam int unsigned SOL_BITS      = 256;

    // Returns row r (col0 = LSB) with every column at or beyond n forced to zero.
    function automatic logic [15:0] row_bytes(input logic [SOL_BITS-1:0] solution,
                                              input int unsigned       r,
                                              input int unsigned       n,
                                              input int unsigned       cols);
        logic [15:0] row;
        int unsigned bitIdx;
        row = '0;
        for (int unsigned c = 0; c < 16; c++) begin
            bitIdx = r * cols + c;
            if (c < n && c < cols && bitIdx < SOL_BITS) begin
                row[c[3:0]] = solution[bitIdx[7:0]];
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/solution_tx_framer.sv
// Serialises a latched solver board into a framed byte stream for uart_tx:
// header, dims, two bytes per active row, then an XOR checksum of the preceding bytes.
module solution_tx_framer
    import tx_frame_pkg::*;
#(
    parameter int          MAX_ROWS       = 11,
    parameter int          MAX_COLS       = 11,
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]   solution,
    input  logic [$clog2(MAX_ROWS)-1:0]    m,
    input  logic [$clog2(MAX_COLS)-1:0]    n,
    input  logic                           transmit_done,
    output logic                           send,
    output logic [7:0]                     byte_out,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int MW = $clog2(MAX_ROWS);
    localparam int NW = $clog2(MAX_COLS);
    localparam int SW = MAX_ROWS * MAX_COLS;
    localparam int IW = $clog2(2 * MAX_ROWS + 4);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q;
    logic [SW-1:0]    sol_q;
    logic [MW-1:0]    m_q;
    logic [NW-1:0]    n_q;
    logic [IW-1:0]    idx_q;
    logic [7:0]       chk_q;
    logic [TW-1:0]    timer_q;
    logic             send_q;
    logic [7:0]       byte_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [SOL_BITS-1:0] solWide;
    logic                dimErr;
    logic [IW-1:0]       lastIdx;
    logic [IW-1:0]       idx_d;
    logic [IW-1:0]       rel;
    logic [15:0]         rowBits;
    logic [7:0]          byte_d;

    assign solWide = SOL_BITS'(sol_q);
    assign dimErr  = ({1'b0, m_q} > (MW+1)'(MAX_ROWS)) || ({1'b0, n_q} > (NW+1)'(MAX_COLS));
    assign lastIdx = dimErr ? IW'(2) : IW'(2) + IW'({m_q, 1'b0});

    // Byte mux for the index that will be sent next; index 0 (header) is loaded on accept.
    always_comb begin
        idx_d   = idx_q + IW'(1);
        rel     = idx_d - IW'(2);
        rowBits = row_bytes(solWide, 32'(rel[IW-1:1]), 32'(n_q), MAX_COLS);
        byte_d  = 8'h00;
        if (idx_d == IW'(1)) begin
            byte_d = dimErr ? DIM_ERR_BYTE : {4'(m_q), 4'(n_q)};
        end else if (idx_d == lastIdx) begin
            byte_d = chk_q;
        end else begin
            byte_d = rel[0] ? rowBits[15:8] : rowBits[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sol_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            timer_q <= '0;
            send_q  <= 1'b0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            send_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        sol_q   <= solution;
                        m_q     <= m;
                        n_q     <= n;
                        err_q   <= 1'b0;
                        chk_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        send_q  <= 1'b1;
                        byte_q  <= HEADER;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (idx_q != lastIdx) begin
                        chk_q <= chk_q ^ byte_q;
                    end
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (transmit_done) begin
                        timer_q <= '0;
                        if (idx_q == lastIdx) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= dimErr;
                            state_q <= FINISH;
                        end else begin
                            idx_q   <= idx_d;
                            send_q  <= 1'b1;
                            byte_q  <= byte_d;
                            state_q <= SEND;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign send     = send_q;
    assign byte_out = byte_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_solution_tx_framer.sv
// Directed scoreboard bench for solution_tx_framer: expected bytes are queued
// when a board is offered and popped as each send pulse appears.
module tb_solution_tx_framer;

    localparam int ROWS = 11;
    localparam int COLS = 11;
    localparam int TO   = 100;

    logic             clk;
    logic             rst;
    logic             validIn;
    logic [ROWS*COLS-1:0] sol;
    logic [3:0]       mIn;
    logic [3:0]       nIn;
    logic             txDone;
    logic             send;
    logic [7:0]       byteOut;
    logic             busy;
    logic             done;
    logic             err;

    logic [7:0] expQ[$];
    int compared;
    int mismatched;

    solution_tx_framer #(
        .MAX_ROWS(ROWS),
        .MAX_COLS(COLS),
        .HEADER(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(validIn),
        .solution(sol),
        .m(mIn),
        .n(nIn),
        .transmit_done(txDone),
        .send(send),
        .byte_out(byteOut),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a board at a negedge; returns at the next negedge (first send expected there).
    task automatic applyStimulus(input logic [ROWS*COLS-1:0] s, input logic [3:0] mm, input logic [3:0] nn);
        sol     = s;
        mIn     = mm;
        nIn     = nn;
        validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic waitSend(input string tag, output bit got, output int waited);
        waited = 0;
        while (send !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        got = (send === 1'b1);
        if (!got) checkOutput({tag, "-sendTimeout"}, 32'(send), 32'd1);
    endtask

    task automatic runFrame(input string tag, input logic expErr, input bit inject);
        int idx = 0;
        bit got;
        int w;
        logic [7:0] exp;
        while (expQ.size() > 0) begin
            waitSend(tag, got, w);
            if (!got) begin
                expQ.delete();
                return;
            end
            exp = expQ.pop_front();
            checkOutput($sformatf("%s-gap%0d", tag, idx), 32'(w), 32'd0);
            checkOutput($sformatf("%s-byte%0d", tag, idx), 32'(byteOut), 32'(exp));
            if (idx == 0) begin
                checkOutput({tag, "-busyFirst"}, 32'(busy), 32'd1);
                checkOutput({tag, "-errCleared"}, 32'(err), 32'd0);
            end
            @(negedge clk);
            if (inject && idx == 1) begin
                validIn = 1'b1;
                mIn     = 4'd2;
                nIn     = 4'd2;
                sol     = '1;
                @(negedge clk);
                validIn = 1'b0;
            end
            txDone = 1'b1;
            @(negedge clk);
            txDone = 1'b0;
            idx++;
        end
        checkOutput({tag, "-done"}, 32'(done), 32'd1);
        checkOutput({tag, "-busyAtDone"}, 32'(busy), 32'd0);
        checkOutput({tag, "-err"}, 32'(err), 32'(expErr));
        @(negedge clk);
        checkOutput({tag, "-doneOnce"}, 32'(done), 32'd0);
        checkOutput({tag, "-sendIdle"}, 32'(send), 32'd0);
    endtask

    initial begin
        logic [ROWS*COLS-1:0] s;
        bit got;
        int w;
        int cnt;
        int sendSeen;
        int doneSeen;

        compared   = 0;
        mismatched = 0;
        rst     = 1'b1;
        validIn = 1'b0;
        sol     = '0;
        mIn     = '0;
        nIn     = '0;
        txDone  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {27'd0, send, busy, done, err, 1'b0}, 32'd0);
        checkOutput("resetByte", 32'(byteOut), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 2x3 board with a masked bit at column 5
        s = '0; s[0] = 1'b1; s[2] = 1'b1; s[12] = 1'b1; s[5] = 1'b1;
        expQ = '{8'hA5, 8'h23, 8'h05, 8'h00, 8'h02, 8'h00, 8'h81};
        applyStimulus(s, 4'd2, 4'd3);
        runFrame("board2x3", 1'b0, 1'b0);

        // full 11x11 board
        expQ.delete();
        expQ.push_back(8'hA5);
        expQ.push_back(8'hBB);
        for (int r = 0; r < 11; r++) begin
            expQ.push_back(8'hFF);
            expQ.push_back(8'h07);
        end
        expQ.push_back(8'hE6);
        applyStimulus('1, 4'd11, 4'd11);
        runFrame("board11x11", 1'b0, 1'b0);

        // empty board, with a valid_in offered mid-frame that must be ignored
        expQ = '{8'hA5, 8'h05, 8'hA0};
        applyStimulus(s, 4'd0, 4'd5);
        runFrame("m0", 1'b0, 1'b1);

        // invalid row count
        expQ = '{8'hA5, 8'hFF, 8'h5A};
        applyStimulus(s, 4'd12, 4'd3);
        runFrame("badDims", 1'b1, 1'b0);

        // stall after the second byte
        applyStimulus(s, 4'd2, 4'd3);
        waitSend("stall", got, w);
        checkOutput("stall-byte0", 32'(byteOut), 32'hA5);
        @(negedge clk);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        waitSend("stall", got, w);
        checkOutput("stall-byte1", 32'(byteOut), 32'h23);
        cnt = 0; sendSeen = 0; doneSeen = 0;
        while (err !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (send === 1'b1) sendSeen++;
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("stall-timeoutCycle", 32'(cnt), 32'(TO + 1));
        checkOutput("stall-err", 32'(err), 32'd1);
        checkOutput("stall-busy", 32'(busy), 32'd0);
        repeat (10) begin
            @(negedge clk);
            if (send === 1'b1) sendSeen++;
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("stall-noSend", 32'(sendSeen), 32'd0);
        checkOutput("stall-noDone", 32'(doneSeen), 32'd0);
        checkOutput("stall-errSticky", 32'(err), 32'd1);

        expQ = '{8'hA5, 8'h23, 8'h05, 8'h00, 8'h02, 8'h00, 8'h81};
        applyStimulus(s, 4'd2, 4'd3);
        runFrame("restart", 1'b0, 1'b0);

        // reset while waiting on the 4th byte
        applyStimulus('1, 4'd11, 4'd11);
        for (int k = 0; k < 4; k++) begin
            waitSend("rstMid", got, w);
            checkOutput($sformatf("rstMid-byte%0d", k), 32'(byteOut), (k == 0) ? 32'hA5 : (k == 1) ? 32'hBB : (k == 2) ? 32'hFF : 32'h07);
            @(negedge clk);
            if (k < 3) begin
                txDone = 1'b1;
                @(negedge clk);
                txDone = 1'b0;
            end
        end
        rst = 1'b1;
        #1;
        checkOutput("rstMid-outputs", {27'd0, send, busy, done, err, 1'b0}, 32'd0);
        checkOutput("rstMid-byteOut", 32'(byteOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sendSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (send === 1'b1) sendSeen++;
        end
        checkOutput("rstMid-noSend", 32'(sendSeen), 32'd0);

        // spurious transmit_done while idle
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        sendSeen = 0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (send === 1'b1) sendSeen++;
            if (busy === 1'b1) cnt++;
        end
        checkOutput("spurious-noSend", 32'(sendSeen), 32'd0);
        checkOutput("spurious-notBusy", 32'(cnt), 32'd0);

        // single row, columns 8..10 masked off
        s = '0;
        for (int c = 0; c < 11; c++) s[c] = 1'b1;
        expQ = '{8'hA5, 8'h18, 8'hFF, 8'h00, 8'h42};
        applyStimulus(s, 4'd1, 4'd8);
        runFrame("row1n8", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
